// File: rtl/tree_walk_pkg.sv
// Shared types and constants for the decision-tree walker: FSM states,
// error codes and node-word field layout helpers.
package tree_walk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } walk_state_e;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_DEPTH    = 2'd1;
  localparam logic [1:0] ERR_FEAT     = 2'd2;
  localparam logic [1:0] ERR_ZERO_REL = 2'd3;

  // Node word, LSB first: is_leaf, right_rel, left_rel, feat_idx, cmp_value.
  function automatic int leaf_bit();
    return 0;
  endfunction

  function automatic int right_lsb();
    return 1;
  endfunction

  function automatic int left_lsb(input int rw);
    return 1 + rw;
  endfunction

  function automatic int fidx_lsb(input int rw);
    return 1 + 2 * rw;
  endfunction

  function automatic int cmp_lsb(input int rw, input int fiw);
    return 1 + 2 * rw + fiw;
  endfunction

  function automatic int node_width(input int fw, input int rw, input int fiw);
    return cmp_lsb(rw, fiw) + fw;
  endfunction

endpackage

// File: rtl/tree_walker_node_eval.sv
// Combinational per-node step: selects the feature, compares it with the
// node threshold and produces the branch direction, next address and error.
module node_eval
  import tree_walk_pkg::*;
#(
  parameter int FW         = 9,
  parameter int RW         = 7,
  parameter int AW         = 14,
  parameter int N_FEAT     = 16,
  parameter int SIGNED_CMP = 0,
  localparam int FIW       = $clog2(N_FEAT),
  localparam int NW        = node_width(FW, RW, FIW)
) (
  input  logic [NW-1:0]        node,
  input  logic [N_FEAT*FW-1:0] feat_vec,
  input  logic [AW-1:0]        cur_addr,
  output logic                 is_leaf,
  output logic [FW-1:0]        leaf_class,
  output logic                 go_left,
  output logic [AW-1:0]        next_addr,
  output logic [1:0]           err
);

  typedef struct packed {
    logic [FW-1:0]  cmp_value;
    logic [FIW-1:0] feat_idx;
    logic [RW-1:0]  left_rel;
    logic [RW-1:0]  right_rel;
    logic           is_leaf;
  } node_t;

  node_t         n;
  logic          idx_bad;
  int            sel;
  logic [FW-1:0] feat_sel;
  logic [RW-1:0] rel_sel;

  assign n = node_t'(node);

  always_comb begin
    idx_bad  = int'(n.feat_idx) >= N_FEAT;
    // Out-of-range index is flagged below; clamp so the part-select stays legal.
    sel      = idx_bad ? 0 : int'(n.feat_idx);
    feat_sel = feat_vec[sel*FW +: FW];
    if (SIGNED_CMP != 0) go_left = $signed(feat_sel) <= $signed(n.cmp_value);
    else                 go_left = feat_sel <= n.cmp_value;
    rel_sel    = go_left ? n.left_rel : n.right_rel;
    next_addr  = cur_addr + AW'(rel_sel);
    is_leaf    = n.is_leaf;
    leaf_class = n.cmp_value;
    if (n.is_leaf)           err = ERR_OK;
    else if (idx_bad)        err = ERR_FEAT;
    else if (rel_sel == '0)  err = ERR_ZERO_REL;
    else                     err = ERR_OK;
  end

endmodule

// File: rtl/tree_walker.sv
// Sequential decision-tree walker: fetches one node per two cycles from the
// node memory and follows relative child offsets until a leaf or an error.
//
// state    | meaning
// ST_IDLE  | ready for a request, latches root address and feature vector
// ST_FETCH | node read strobe issued at cur_addr
// ST_EVAL  | node word present, decide leaf / error / next child
// ST_DONE  | result held on out_* until out_ready
module tree_walker
  import tree_walk_pkg::*;
#(
  parameter int FW         = 9,
  parameter int RW         = 7,
  parameter int AW         = 14,
  parameter int N_FEAT     = 16,
  parameter int MAX_DEPTH  = 16,
  parameter int SIGNED_CMP = 0,
  localparam int FIW       = $clog2(N_FEAT),
  localparam int NW        = node_width(FW, RW, FIW),
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 ready,
  input  logic [AW-1:0]        root_addr,
  input  logic [N_FEAT*FW-1:0] feat_vec,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [NW-1:0]        mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FW-1:0]        out_class,
  output logic [DW-1:0]        out_depth,
  output logic [1:0]           out_err
);

  walk_state_e          state_q, state_d;
  logic [AW-1:0]        cur_addr_q, cur_addr_d;
  logic [N_FEAT*FW-1:0] feat_q, feat_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic                 out_valid_q, out_valid_d;
  logic [FW-1:0]        out_class_q, out_class_d;
  logic [DW-1:0]        out_depth_q, out_depth_d;
  logic [1:0]           out_err_q, out_err_d;

  logic          ne_is_leaf;
  logic [FW-1:0] ne_class;
  logic          ne_go_left;
  logic [AW-1:0] ne_next_addr;
  logic [1:0]    ne_err;

  node_eval #(
    .FW(FW), .RW(RW), .AW(AW), .N_FEAT(N_FEAT), .SIGNED_CMP(SIGNED_CMP)
  ) u_node_eval (
    .node       (mem_rdata),
    .feat_vec   (feat_q),
    .cur_addr   (cur_addr_q),
    .is_leaf    (ne_is_leaf),
    .leaf_class (ne_class),
    .go_left    (ne_go_left),
    .next_addr  (ne_next_addr),
    .err        (ne_err)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    feat_d      = feat_q;
    depth_d     = depth_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_depth_d = out_depth_q;
    out_err_d   = out_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          cur_addr_d  = root_addr;
          feat_d      = feat_vec;
          depth_d     = '0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = root_addr;
        end
      end
      ST_FETCH: begin
        mem_rd_en_d = 1'b0;
        state_d     = ST_EVAL;
      end
      ST_EVAL: begin
        out_depth_d = depth_q;
        if (ne_is_leaf) begin
          out_class_d = ne_class;
          out_err_d   = ERR_OK;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (ne_err != ERR_OK) begin
          out_class_d = '0;
          out_err_d   = ne_err;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (depth_q == DW'(MAX_DEPTH)) begin
          out_class_d = '0;
          out_err_d   = ERR_DEPTH;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          depth_d     = depth_q + DW'(1);
          cur_addr_d  = ne_next_addr;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = ne_next_addr;
          state_d     = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      feat_q      <= '0;
      depth_q     <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_depth_q <= '0;
      out_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      feat_q      <= feat_d;
      depth_q     <= depth_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_depth_q <= out_depth_d;
      out_err_q   <= out_err_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_depth = out_depth_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_tree_walker.sv
// Directed bench for tree_walker: an unsigned 16-feature instance and a
// signed 12-feature instance share one node memory model.
module tb_tree_walker;
  import tree_walk_pkg::*;

  localparam int FW  = 9;
  localparam int RW  = 7;
  localparam int AW  = 14;
  localparam int FIW = 4;
  localparam int NW  = node_width(FW, RW, FIW);
  localparam int DW  = 5;
  localparam int FVU = 16 * FW;
  localparam int FVS = 12 * FW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NW-1:0] mem [0:16383];

  logic           u_start = 1'b0, u_ready, u_rd_en, u_valid, u_oready = 1'b0;
  logic [AW-1:0]  u_root = '0, u_addr;
  logic [FVU-1:0] u_feat = '0;
  logic [NW-1:0]  u_rdata = '0;
  logic [FW-1:0]  u_class;
  logic [DW-1:0]  u_depth;
  logic [1:0]     u_err;

  logic           s_start = 1'b0, s_ready, s_rd_en, s_valid, s_oready = 1'b0;
  logic [AW-1:0]  s_root = '0, s_addr;
  logic [FVS-1:0] s_feat = '0;
  logic [NW-1:0]  s_rdata = '0;
  logic [FW-1:0]  s_class;
  logic [DW-1:0]  s_depth;
  logic [1:0]     s_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] u_log [$];

  tree_walker u_dut (
    .clk(clk), .rst_n(rst_n), .start(u_start), .ready(u_ready),
    .root_addr(u_root), .feat_vec(u_feat), .mem_rd_en(u_rd_en),
    .mem_addr(u_addr), .mem_rdata(u_rdata), .out_valid(u_valid),
    .out_ready(u_oready), .out_class(u_class), .out_depth(u_depth),
    .out_err(u_err)
  );

  tree_walker #(.N_FEAT(12), .SIGNED_CMP(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .start(s_start), .ready(s_ready),
    .root_addr(s_root), .feat_vec(s_feat), .mem_rd_en(s_rd_en),
    .mem_addr(s_addr), .mem_rdata(s_rdata), .out_valid(s_valid),
    .out_ready(s_oready), .out_class(s_class), .out_depth(s_depth),
    .out_err(s_err)
  );

  always @(posedge clk) begin
    if (u_rd_en) u_rdata <= mem[u_addr];
    if (s_rd_en) s_rdata <= mem[s_addr];
  end

  always @(negedge clk) if (u_rd_en) u_log.push_back(u_addr);

  function automatic logic [NW-1:0] mk_int(input int idx, input int cmp, input int l, input int r);
    logic [NW-1:0] n;
    n = '0;
    n[right_lsb() +: RW]        = RW'(r);
    n[left_lsb(RW) +: RW]       = RW'(l);
    n[fidx_lsb(RW) +: FIW]      = FIW'(idx);
    n[cmp_lsb(RW, FIW) +: FW]   = FW'(cmp);
    return n;
  endfunction

  function automatic logic [NW-1:0] mk_leaf(input int cls);
    logic [NW-1:0] n;
    n = '0;
    n[leaf_bit()]             = 1'b1;
    n[cmp_lsb(RW, FIW) +: FW] = FW'(cls);
    return n;
  endfunction

  task automatic run_u(input logic [AW-1:0] root, input logic [FVU-1:0] fv, output int lat);
    u_log.delete();
    @(negedge clk);
    u_start = 1'b1; u_root = root; u_feat = fv;
    lat = 0;
    do begin
      @(negedge clk);
      u_start = 1'b0;
      lat++;
    end while (!u_valid && lat < 200);
    n_checks++;
    if (u_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL run_u_timeout: out_valid=%b after %0d cycles, required 1", u_valid, lat);
    end
  endtask

  task automatic run_s(input logic [AW-1:0] root, input logic [FVS-1:0] fv, output int lat);
    @(negedge clk);
    s_start = 1'b1; s_root = root; s_feat = fv;
    lat = 0;
    do begin
      @(negedge clk);
      s_start = 1'b0;
      lat++;
    end while (!s_valid && lat < 200);
    n_checks++;
    if (s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL run_s_timeout: out_valid=%b after %0d cycles, required 1", s_valid, lat);
    end
  endtask

  task automatic finish_u();
    @(negedge clk); u_oready = 1'b1;
    @(negedge clk); u_oready = 1'b0;
  endtask

  task automatic finish_s();
    @(negedge clk); s_oready = 1'b1;
    @(negedge clk); s_oready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({u_ready, u_rd_en, u_addr, u_valid, u_class, u_depth, u_err} !== {1'b1, 1'b0, 14'd0, 1'b0, 9'd0, 5'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b rd=%b addr=%0d v=%b cls=%0d d=%0d e=%0d, required 1 0 0 0 0 0 0",
               u_ready, u_rd_en, u_addr, u_valid, u_class, u_depth, u_err);
    end
  endtask

  task automatic test_root_leaf();
    int lat;
    run_u(14'd100, '0, lat);
    n_checks++;
    if ({lat, u_class, u_depth, u_err} !== {32'd3, 9'd5, 5'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL root_leaf: lat=%0d cls=%0d d=%0d e=%0d, required 3 5 0 0", lat, u_class, u_depth, u_err);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({u_valid, u_class, u_depth, u_err, u_ready} !== {1'b1, 9'd5, 5'd0, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: v=%b cls=%0d d=%0d e=%0d rdy=%b, required 1 5 0 0 0",
                 i, u_valid, u_class, u_depth, u_err, u_ready);
      end
    end
    finish_u();
    n_checks++;
    if ({u_ready, u_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL handshake_ready: rdy=%b v=%b, required 1 0", u_ready, u_valid);
    end
  endtask

  task automatic test_left_path();
    int lat;
    logic [FVU-1:0] fv;
    fv = '0; fv[3*FW +: FW] = 9'd40;
    run_u(14'd100 + 14'd0, fv, lat);
    n_checks++;
    if ({lat, u_class, u_depth, u_err} !== {32'd5, 9'd7, 5'd1, 2'd0}) begin
      n_fail++;
      $display("FAIL left_path: lat=%0d cls=%0d d=%0d e=%0d, required 5 7 1 0", lat, u_class, u_depth, u_err);
    end
    n_checks++;
    if (u_log.size() != 2 || u_log[0] !== 14'd100 || u_log[1] !== 14'd102) begin
      n_fail++;
      $display("FAIL left_path_addrs: n=%0d first=%0d second=%0d, required 2 100 102",
               u_log.size(), u_log.size() > 0 ? u_log[0] : 14'd0, u_log.size() > 1 ? u_log[1] : 14'd0);
    end
    finish_u();
  endtask

  task automatic test_equal_right();
    int lat;
    logic [FVU-1:0] fv;
    fv = '0; fv[3*FW +: FW] = 9'd50;
    run_u(14'd100, fv, lat);
    n_checks++;
    if (u_class !== 9'd7) begin
      n_fail++;
      $display("FAIL equal_goes_left: cls=%0d, required 7", u_class);
    end
    finish_u();
    fv[3*FW +: FW] = 9'd51;
    run_u(14'd100, fv, lat);
    n_checks++;
    if ({u_class, u_depth} !== {9'd11, 5'd1} || u_log.size() != 2 || u_log[1] !== 14'd109) begin
      n_fail++;
      $display("FAIL greater_goes_right: cls=%0d d=%0d, required 11 1 via 109", u_class, u_depth);
    end
    finish_u();
    fv[3*FW +: FW] = 9'h1FF;
    run_u(14'd200, fv, lat);
    n_checks++;
    if (u_class !== 9'd22) begin
      n_fail++;
      $display("FAIL unsigned_1ff_vs_0: cls=%0d, required 22", u_class);
    end
    finish_u();
  endtask

  task automatic test_signed();
    int lat;
    logic [FVS-1:0] fv;
    fv = '0; fv[3*FW +: FW] = 9'h1FF;
    run_s(14'd200, fv, lat);
    n_checks++;
    if ({lat, s_class, s_depth, s_err} !== {32'd5, 9'd21, 5'd1, 2'd0}) begin
      n_fail++;
      $display("FAIL signed_neg1_vs_0: lat=%0d cls=%0d d=%0d e=%0d, required 5 21 1 0", lat, s_class, s_depth, s_err);
    end
    finish_s();
  endtask

  task automatic test_feat_err();
    int lat;
    logic [FVS-1:0] fv;
    fv = '0;
    run_s(14'd400, fv, lat);
    n_checks++;
    if ({lat, s_class, s_depth, s_err} !== {32'd3, 9'd0, 5'd0, 2'd2}) begin
      n_fail++;
      $display("FAIL feat_idx_range: lat=%0d cls=%0d d=%0d e=%0d, required 3 0 0 2", lat, s_class, s_depth, s_err);
    end
    finish_s();
  endtask

  task automatic test_wrap();
    int lat;
    logic [FVU-1:0] fv;
    fv = '0; fv[0 +: FW] = 9'd5;
    run_u(14'd16383, fv, lat);
    n_checks++;
    if ({u_class, u_err} !== {9'd33, 2'd0} || u_log.size() != 2 || u_log[1] !== 14'd2) begin
      n_fail++;
      $display("FAIL addr_wrap: cls=%0d e=%0d n=%0d, required 33 0 with second fetch at 2", u_class, u_err, u_log.size());
    end
    finish_u();
  endtask

  task automatic test_zero_rel();
    int lat;
    logic [FVU-1:0] fv;
    fv = '0; fv[0 +: FW] = 9'd5;
    run_u(14'd300, fv, lat);
    n_checks++;
    if ({lat, u_class, u_depth, u_err} !== {32'd3, 9'd0, 5'd0, 2'd3}) begin
      n_fail++;
      $display("FAIL zero_rel: lat=%0d cls=%0d d=%0d e=%0d, required 3 0 0 3", lat, u_class, u_depth, u_err);
    end
    finish_u();
  endtask

  task automatic test_depth();
    int lat;
    logic [FVU-1:0] fv;
    fv = '0; fv[0 +: FW] = 9'd5;
    run_u(14'd1000, fv, lat);
    n_checks++;
    if ({lat, u_class, u_depth, u_err} !== {32'd35, 9'd0, 5'd16, 2'd1}) begin
      n_fail++;
      $display("FAIL depth_overflow: lat=%0d cls=%0d d=%0d e=%0d, required 35 0 16 1", lat, u_class, u_depth, u_err);
    end
    finish_u();
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    logic [FVU-1:0] fv;
    fv = '0; fv[3*FW +: FW] = 9'd40;
    u_log.delete();
    @(negedge clk); u_start = 1'b1; u_root = 14'd100; u_feat = fv;
    @(negedge clk); u_start = 1'b0;
    @(negedge clk); u_start = 1'b1; u_root = 14'd500;
    @(negedge clk); u_start = 1'b0;
    lat = 0;
    while (!u_valid && lat < 100) begin @(negedge clk); lat++; end
    n_checks++;
    if (u_class !== 9'd7 || u_log.size() != 2) begin
      n_fail++;
      $display("FAIL start_during_walk: cls=%0d fetches=%0d, required 7 2", u_class, u_log.size());
    end
    finish_u();
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (u_valid || u_rd_en || !u_ready) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL start_not_queued: busy cycles=%0d, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_u(14'd100, '0, lat);
    finish_u();
    run_u(14'd500, '0, lat);
    n_checks++;
    if ({lat, u_class} !== {32'd3, 9'd99}) begin
      n_fail++;
      $display("FAIL back_to_back: lat=%0d cls=%0d, required 3 99", lat, u_class);
    end
    finish_u();
  endtask

  task automatic test_reset_mid();
    logic [FVU-1:0] fv;
    fv = '0; fv[0 +: FW] = 9'd5;
    @(negedge clk); u_start = 1'b1; u_root = 14'd1000; u_feat = fv;
    for (int i = 0; i < 4; i++) begin @(negedge clk); u_start = 1'b0; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({u_ready, u_rd_en, u_addr, u_valid, u_class, u_depth, u_err} !== {1'b1, 1'b0, 14'd0, 1'b0, 9'd0, 5'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_walk: rdy=%b rd=%b addr=%0d v=%b cls=%0d d=%0d e=%0d, required 1 0 0 0 0 0 0",
               u_ready, u_rd_en, u_addr, u_valid, u_class, u_depth, u_err);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_checks++;
    if ({u_ready, u_rd_en, u_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL after_reset_release: rdy=%b rd=%b v=%b, required 1 0 0", u_ready, u_rd_en, u_valid);
    end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = '0;
    mem[100] = mk_int(3, 50, 2, 9);
    mem[102] = mk_leaf(7);
    mem[109] = mk_leaf(11);
    mem[200] = mk_int(3, 0, 1, 2);
    mem[201] = mk_leaf(21);
    mem[202] = mk_leaf(22);
    mem[300] = mk_int(0, 0, 1, 0);
    mem[400] = mk_int(13, 0, 1, 1);
    mem[500] = mk_leaf(99);
    mem[16383] = mk_int(0, 0, 1, 3);
    mem[2] = mk_leaf(33);
    for (int a = 1000; a <= 1016; a++) mem[a] = mk_int(0, 0, 1, 1);
    mem[1017] = mk_leaf(44);
    mem[100 - 100] = mem[0];
    mem[100] = mk_int(3, 50, 2, 9);

    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    mem[100] = mk_leaf(5);
    test_root_leaf();
    test_backpressure();
    mem[100] = mk_int(3, 50, 2, 9);
    test_left_path();
    test_equal_right();
    test_signed();
    test_feat_err();
    test_wrap();
    test_zero_rel();
    test_depth();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
